// File: rtl/chan_arb_pkg.sv
// Shared types and helpers for the channel stream arbiter.
// Optional source tagging is enabled by defining CHAN_ARB_TAG_EN.
package chan_arb_pkg;

   localparam int unsigned CHAN_DATA_W    = 64;
   localparam int unsigned CHAN_MAX_BURST = 16;
   localparam int unsigned RR_MAX_REQ     = 32;
   localparam int unsigned RR_IDX_W       = 5;
   localparam int unsigned RR_PTR_W       = RR_IDX_W + 1;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_t;

   // First set bit of valid at or after ptr, wrapping at num_req; the lowest offset wins.
   function automatic logic [RR_PTR_W-1:0] rr_pick(
      input logic [RR_MAX_REQ-1:0] valid,
      input logic [RR_PTR_W-1:0]   ptr,
      input logic [RR_PTR_W-1:0]   num_req
   );
      logic [RR_PTR_W-1:0] off;
      logic [RR_PTR_W-1:0] idx;
      logic [RR_PTR_W-1:0] pick;
      pick = ptr;
      for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
         off = RR_PTR_W'(RR_MAX_REQ - 1 - k);
         idx = ptr + off;
         if (idx >= num_req) idx = idx - num_req;
         if ((off < num_req) && valid[idx[RR_IDX_W-1:0]]) pick = idx;
      end
      return pick;
   endfunction

endpackage

// File: rtl/chan_stream_arbiter_skid.sv
// Two-entry registered FIFO decoupling downstream ready from the producers.
// Module name chan_skid_buf; width W covers data plus optional source id.
module chan_skid_buf
   import chan_arb_pkg::*;
#(
   parameter int unsigned W = CHAN_DATA_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_ready
);

   logic [1:0][W-1:0] mem_q, mem_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic [1:0]        count_q, count_d;
   logic              push, pop;

   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign out_data  = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      push     = in_valid & in_ready;
      pop      = out_valid & out_ready;
      if (push) begin
         mem_d[wr_ptr_q] = in_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + 2'(push) - 2'(pop);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q    <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/chan_stream_arbiter.sv
// Round-robin burst arbiter sharing one Avalon-ST channel sink among NUM_REQ producers.
// Define CHAN_ARB_TAG_EN to add the out_chan source-id port.
module chan_stream_arbiter
   import chan_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ   = 4,
   parameter  int unsigned DATA_W    = CHAN_DATA_W,
   parameter  int unsigned MAX_BURST = CHAN_MAX_BURST,
   localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ*DATA_W-1:0] in_data,
   input  logic [NUM_REQ-1:0]        in_valid,
   output logic [NUM_REQ-1:0]        in_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_valid,
`ifdef CHAN_ARB_TAG_EN
   output logic [ID_W-1:0]           out_chan,
`endif
   input  logic                      out_ready
);

   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
`ifdef CHAN_ARB_TAG_EN
   localparam int unsigned SKID_W = ID_W + DATA_W;
`else
   localparam int unsigned SKID_W = DATA_W;
`endif

   arb_state_t        state_q, state_d;
   logic [ID_W-1:0]   gnt_q, gnt_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   gnt_next;
   logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic              skid_ready;
   logic              push;
   logic              gnt_valid;
   logic [DATA_W-1:0] gnt_data;
   logic [SKID_W-1:0] push_word;
   logic [SKID_W-1:0] pop_word;

   assign gnt_valid = in_valid[gnt_q];
   assign gnt_data  = in_data[gnt_q*DATA_W +: DATA_W];
   assign gnt_next  = (gnt_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_q + ID_W'(1);

   // Next-state, grant and per-requester ready; in_ready never looks at out_ready.
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      in_ready   = '0;
      push       = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (|in_valid) begin
               gnt_d      = ID_W'(rr_pick(RR_MAX_REQ'(in_valid), RR_PTR_W'(rr_ptr_q),
                                          RR_PTR_W'(NUM_REQ)));
               beat_cnt_d = '0;
               state_d    = ARB_BURST;
            end
         end
         ARB_BURST: begin
            in_ready[gnt_q] = skid_ready;
            if (!gnt_valid) begin
               state_d    = ARB_IDLE;
               rr_ptr_d   = gnt_next;
               beat_cnt_d = '0;
            end else if (skid_ready) begin
               push = 1'b1;
               if (beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                  state_d    = ARB_IDLE;
                  rr_ptr_d   = gnt_next;
                  beat_cnt_d = '0;
               end else begin
                  beat_cnt_d = beat_cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ARB_IDLE;
         gnt_q      <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

`ifdef CHAN_ARB_TAG_EN
   assign push_word            = {gnt_q, gnt_data};
   assign {out_chan, out_data} = pop_word;
`else
   assign push_word = gnt_data;
   assign out_data  = pop_word;
`endif

   chan_skid_buf #(
      .W (SKID_W)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (push),
      .in_data   (push_word),
      .in_ready  (skid_ready),
      .out_valid (out_valid),
      .out_data  (pop_word),
      .out_ready (out_ready)
   );

endmodule

// File: tb/tb_chan_stream_arbiter.sv
// Directed self-checking bench for chan_stream_arbiter (tag checks when CHAN_ARB_TAG_EN is defined).
module tb_chan_stream_arbiter;

   localparam int unsigned NUM_REQ   = 4;
   localparam int unsigned DATA_W    = 64;
   localparam int unsigned MAX_BURST = 16;
   localparam int unsigned ID_W      = 2;

   logic                      clk = 1'b0;
   logic                      reset;
   logic [NUM_REQ*DATA_W-1:0] in_data;
   logic [NUM_REQ-1:0]        in_valid;
   logic [NUM_REQ-1:0]        in_ready;
   logic [DATA_W-1:0]         out_data;
   logic                      out_valid;
   logic                      out_ready;
`ifdef CHAN_ARB_TAG_EN
   logic [ID_W-1:0]           out_chan;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int rem [NUM_REQ];
   int seq [NUM_REQ];
   int          acc_src  [$];
   int          acc_cyc  [$];
   logic [63:0] acc_data [$];
   logic [63:0] got_data [$];
   int          got_cyc  [$];
   int          got_chan [$];

   always #5 clk = ~clk;

   chan_stream_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .DATA_W    (DATA_W),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
`ifdef CHAN_ARB_TAG_EN
      .out_chan  (out_chan),
`endif
      .out_ready (out_ready)
   );

   function automatic logic [63:0] beat(input int i, input int k);
      return {32'(i), 32'(k)};
   endfunction

   function automatic logic [63:0] gd(input int k);
      return (k < got_data.size()) ? got_data[k] : 64'hx;
   endfunction

   function automatic int gc(input int k);
      return (k < got_cyc.size()) ? got_cyc[k] : -1000;
   endfunction

   function automatic int gch(input int k);
      return (k < got_chan.size()) ? got_chan[k] : -1;
   endfunction

   function automatic int ac(input int k);
      return (k < acc_cyc.size()) ? acc_cyc[k] : -2000;
   endfunction

   function automatic int as(input int k);
      return (k < acc_src.size()) ? acc_src[k] : -1;
   endfunction

   function automatic logic [63:0] ad(input int k);
      return (k < acc_data.size()) ? acc_data[k] : 64'hx;
   endfunction

   task automatic drive();
      for (int i = 0; i < NUM_REQ; i++) begin
         in_valid[i] = (rem[i] != 0);
         in_data[i*DATA_W +: DATA_W] = beat(i, seq[i]);
      end
   endtask

   task automatic clear_log();
      acc_src.delete(); acc_cyc.delete(); acc_data.delete();
      got_data.delete(); got_cyc.delete(); got_chan.delete();
      cyc = 0;
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < NUM_REQ; i++) begin
         rem[i] = 0;
         seq[i] = 0;
      end
   endtask

   // One clock: sample handshakes at the negedge, let the edge pass, update the producers.
   task automatic cycle();
      logic [NUM_REQ-1:0] f_in;
      logic               f_out;
      logic [63:0]        od;
      int                 oc;
      f_in  = in_valid & in_ready;
      f_out = out_valid & out_ready;
      od    = out_data;
      oc    = 0;
`ifdef CHAN_ARB_TAG_EN
      oc    = int'(out_chan);
`endif
      checks++;
      if (!$onehot0(in_ready)) begin
         errors++;
         $display("FAIL ready_onehot cyc %0d: in_ready=%b, required at most one bit", cyc, in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (f_in[i]) begin
            acc_src.push_back(i);
            acc_cyc.push_back(cyc);
            acc_data.push_back(beat(i, seq[i]));
            seq[i]++;
            rem[i]--;
         end
      end
      if (f_out) begin
         got_data.push_back(od);
         got_cyc.push_back(cyc);
         got_chan.push_back(oc);
      end
      cyc++;
      drive();
   endtask

   task automatic run_out(input int n, input int budget, input string name);
      int b;
      b = 0;
      while (got_data.size() < n && b < budget) begin
         cycle();
         b++;
      end
      checks++;
      if (got_data.size() < n) begin
         errors++;
         $display("FAIL %s_timeout: got %0d output beats, required %0d", name, got_data.size(), n);
      end
   endtask

   task automatic run_acc(input int n, input int budget, input string name);
      int b;
      b = 0;
      while (acc_src.size() < n && b < budget) begin
         cycle();
         b++;
      end
      checks++;
      if (acc_src.size() < n) begin
         errors++;
         $display("FAIL %s_timeout: got %0d accepted beats, required %0d", name, acc_src.size(), n);
      end
   endtask

   task automatic reset_dut();
      reset     = 1'b1;
      out_ready = 1'b1;
      clear_reqs();
      drive();
      clear_log();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_data !== 64'h0 || in_ready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b data=%h ready=%b, required 0/0/0",
                  out_valid, out_data, in_ready);
      end
`ifdef CHAN_ARB_TAG_EN
      checks++;
      if (out_chan !== 2'd0) begin
         errors++;
         $display("FAIL reset_chan: out_chan=%0d, required 0", out_chan);
      end
`endif
      reset = 1'b0;
      repeat (3) cycle();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_idle: valid=%b ready=%b, required 0/0", out_valid, in_ready);
      end
   endtask

   task automatic test_single();
      reset_dut();
      rem[2] = 5;
      drive();
      run_out(5, 40, "single");
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (gd(k) !== beat(2, k)) begin
            errors++;
            $display("FAIL single_data[%0d]: got %h, required %h", k, gd(k), beat(2, k));
         end
         checks++;
         if (gc(k) != ac(k) + 1) begin
            errors++;
            $display("FAIL single_latency[%0d]: out cycle %0d, required %0d", k, gc(k), ac(k) + 1);
         end
      end
      checks++;
      if (ac(4) - ac(0) != 4) begin
         errors++;
         $display("FAIL single_contig: span %0d cycles, required 4", ac(4) - ac(0));
      end
      repeat (3) cycle();
      checks++;
      if (in_ready !== 4'b0000) begin
         errors++;
         $display("FAIL single_release: in_ready=%b, required 0000", in_ready);
      end
      rem[1] = 1;
      rem[3] = 1;
      drive();
      run_acc(7, 20, "single_next");
      checks++;
      if (as(5) != 3 || as(6) != 1) begin
         errors++;
         $display("FAIL single_rr_ptr: grant order %0d,%0d, required 3,1", as(5), as(6));
      end
   endtask

   task automatic test_round_robin();
      int nseq [NUM_REQ];
      int bad;
      int src;
      reset_dut();
      for (int i = 0; i < NUM_REQ; i++) rem[i] = 1000;
      drive();
      run_acc(80, 200, "rr");
      clear_reqs();
      drive();
      repeat (4) cycle();
      for (int i = 0; i < NUM_REQ; i++) nseq[i] = 0;
      for (int g = 0; g < 5; g++) begin
         src = g % 4;
         bad = 0;
         for (int b = 0; b < 16; b++) begin
            if (as(g*16 + b) != src || ad(g*16 + b) !== beat(src, nseq[src])) bad++;
            nseq[src]++;
         end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL rr_grant[%0d]: %0d wrong beats, required 16 beats from %0d", g, bad, src);
         end
         checks++;
         if (ac(g*16 + 15) - ac(g*16) != 15) begin
            errors++;
            $display("FAIL rr_contig[%0d]: span %0d, required 15", g, ac(g*16 + 15) - ac(g*16));
         end
         if (g < 4) begin
            checks++;
            if (ac((g+1)*16) - ac(g*16 + 15) != 2) begin
               errors++;
               $display("FAIL rr_bubble[%0d]: gap %0d, required 2", g, ac((g+1)*16) - ac(g*16 + 15));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int bad;
      reset_dut();
      out_ready = 1'b0;
      rem[1] = 20;
      drive();
      repeat (10) cycle();
      checks++;
      if (acc_src.size() != 2) begin
         errors++;
         $display("FAIL bp_accepted: %0d beats accepted while stalled, required 2", acc_src.size());
      end
      checks++;
      if (in_ready !== 4'b0000) begin
         errors++;
         $display("FAIL bp_ready: in_ready=%b, required 0000", in_ready);
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== beat(1, 0)) begin
         errors++;
         $display("FAIL bp_head: valid=%b data=%h, required 1/%h", out_valid, out_data, beat(1, 0));
      end
      out_ready = 1'b1;
      run_out(20, 60, "bp");
      bad = 0;
      for (int k = 0; k < 20; k++) if (gd(k) !== beat(1, k)) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL bp_order: %0d beats wrong or missing, required 0", bad);
      end
      repeat (5) cycle();
      checks++;
      if (got_data.size() != 20 || acc_src.size() != 20) begin
         errors++;
         $display("FAIL bp_count: out %0d accepted %0d, required 20/20", got_data.size(), acc_src.size());
      end
   endtask

   task automatic test_wrap();
      int exp_src [7];
      int exp_seq [7];
      int bad;
      exp_src = '{2, 3, 3, 3, 0, 0, 0};
      exp_seq = '{0, 0, 1, 2, 0, 1, 2};
      reset_dut();
      rem[2] = 1;
      drive();
      run_out(1, 10, "wrap_pre");
      repeat (3) cycle();
      rem[3] = 3;
      rem[0] = 3;
      drive();
      run_acc(7, 40, "wrap");
      bad = 0;
      for (int k = 0; k < 7; k++)
         if (as(k) != exp_src[k] || ad(k) !== beat(exp_src[k], exp_seq[k])) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL wrap_order: %0d beats wrong, first grants %0d,%0d,%0d, required 2,3,0",
                  bad, as(0), as(1), as(4));
      end
   endtask

   task automatic test_reset_mid_burst();
      reset_dut();
      out_ready = 1'b0;
      rem[2] = 20;
      drive();
      repeat (5) cycle();
      checks++;
      if (out_valid !== 1'b1 || acc_src.size() != 2) begin
         errors++;
         $display("FAIL rst_pre: valid=%b accepted=%0d, required 1/2", out_valid, acc_src.size());
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
         errors++;
         $display("FAIL rst_async: valid=%b ready=%b, required 0/0000", out_valid, in_ready);
      end
      checks++;
      if (out_data !== 64'h0) begin
         errors++;
         $display("FAIL rst_data: out_data=%h, required 0", out_data);
      end
      @(negedge clk);
      @(negedge clk);
      clear_reqs();
      clear_log();
      out_ready = 1'b1;
      rem[1] = 1;
      rem[3] = 1;
      drive();
      reset = 1'b0;
      run_out(2, 20, "rst_after");
      repeat (4) cycle();
      checks++;
      if (got_data.size() != 2) begin
         errors++;
         $display("FAIL rst_flush: %0d output beats, required 2", got_data.size());
      end
      checks++;
      if (gd(0) !== beat(1, 0) || gd(1) !== beat(3, 0)) begin
         errors++;
         $display("FAIL rst_restart: got %h,%h, required %h,%h", gd(0), gd(1), beat(1, 0), beat(3, 0));
      end
   endtask

`ifdef CHAN_ARB_TAG_EN
   task automatic test_tag();
      int exp_src [6];
      int exp_seq [6];
      exp_src = '{1, 1, 3, 3, 1, 3};
      exp_seq = '{0, 1, 0, 1, 2, 2};
      reset_dut();
      rem[1] = 2;
      rem[3] = 2;
      drive();
      run_out(4, 30, "tag_a");
      rem[1] = 1;
      rem[3] = 1;
      drive();
      run_out(6, 30, "tag_b");
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (gch(k) != exp_src[k] || gd(k) !== beat(exp_src[k], exp_seq[k])) begin
            errors++;
            $display("FAIL tag_chan[%0d]: chan=%0d data=%h, required %0d/%h",
                     k, gch(k), gd(k), exp_src[k], beat(exp_src[k], exp_seq[k]));
         end
      end
   endtask
`endif

   initial begin
      reset     = 1'b1;
      out_ready = 1'b1;
      in_valid  = '0;
      in_data   = '0;
      clear_reqs();
      drive();
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_wrap();
      test_reset_mid_burst();
`ifdef CHAN_ARB_TAG_EN
      test_tag();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/chan_stream_arbiter.md
# chan_stream_arbiter

Round-robin, burst-granting arbiter that shares one 64-bit Avalon-ST channel sink (the kernel-facing `data_source` stream of the OpenCL board system) among several producer streams. It sits in the board fabric between the producer interfaces and the single channel endpoint. It sequences grants with a bounded burst length and registers the output through a 2-entry skid buffer, so downstream backpressure never forms a combinational path to the producers.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requester streams; minimum 2.
- `DATA_W`, 64: beat width in bits.
- `MAX_BURST`, 16: maximum beats per grant; minimum 1.
- `ID_W` (localparam): `$clog2(NUM_REQ)`.

Ports:
- `clk`  in  1  kernel clock; the block has one clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_data`  in  NUM_REQ*DATA_W  requester beats; requester i occupies bits [i*DATA_W +: DATA_W].
- `in_valid`  in  NUM_REQ  per-requester valid.
- `in_ready`  out  NUM_REQ  per-requester ready; at most one bit is high.
- `out_data`  out  DATA_W  channel beat.
- `out_valid`  out  1  channel valid.
- `out_ready`  in  1  channel ready.
- `out_chan`  out  ID_W  source id of the current out_data beat. Present only with `CHAN_ARB_TAG_EN`.

## Operation
- FSM has two states: IDLE and BURST.
- IDLE:
  - Scan `in_valid` starting at `rr_ptr`, wrapping modulo NUM_REQ. The first set bit becomes `gnt`.
  - On the next cycle the FSM is in BURST and `beat_cnt` is 0.
  - If no `in_valid` bit is set, stay in IDLE.
  - `in_ready` is all zero while in IDLE.
- BURST:
  - `in_ready[gnt]` equals `~skid_full`. All other `in_ready` bits are 0.
  - A beat transfers on `in_valid[gnt] & in_ready[gnt]` and increments `beat_cnt`.
- Leaving BURST for IDLE happens when either:
  - a transfer makes `beat_cnt` reach MAX_BURST, or
  - `in_valid[gnt]` is 0 in any BURST cycle. In that case no transfer occurs and the grant is released.
- On every BURST exit, `rr_ptr` becomes `(gnt+1) mod NUM_REQ`, including wrap from NUM_REQ-1 to 0.
- Skid buffer:
  - 2-entry FIFO with occupancy 0–2; `skid_full` is (occupancy==2).
  - `out_valid` is high when occupancy is nonzero; `out_data` is the head entry.
  - On a simultaneous push and pop, occupancy is unchanged and order is preserved.
- A stalled `out_ready` never drops or duplicates a beat. The producer stalls once the skid is full.
- Beats from one grant are contiguous and in order. Beats of different grants never interleave.

## Timing
- Grant latency: 1 cycle. The first beat can be accepted in the cycle after the IDLE cycle that chose it.
- Each grant costs one IDLE bubble.
- Data latency: a beat accepted on cycle N appears on `out_data`/`out_valid` on cycle N+1 if the skid was empty.
- `in_ready`, `out_valid`, `out_data` and `out_chan` are driven from registers or from FSM/occupancy state only. None depends combinationally on `out_ready`.
- Sustained throughput is 1 beat/cycle within a burst while `out_ready` is high. Per grant it is MAX_BURST/(MAX_BURST+1).
- Reset values: `out_valid`=0, `out_data`=0, `out_chan`=0, `in_ready`=0, state=IDLE, `rr_ptr`=0, `beat_cnt`=0, occupancy=0.
- Reset mid-burst discards skid contents and the in-flight grant immediately. No partial burst resumes.

## Configuration
- `CHAN_ARB_TAG_EN` defined:
  - the `out_chan` port exists;
  - the skid stores `{id, data}`;
  - `out_chan` is valid whenever `out_valid` is high.
- `CHAN_ARB_TAG_EN` undefined:
  - the port is absent and the skid stores data only;
  - behaviour is otherwise identical.

## Structure
- Shared package `chan_arb_pkg`:
  - state enum `arb_state_t` {ARB_IDLE, ARB_BURST};
  - function `rr_pick(valid, ptr)` returning the granted index;
  - default constants `CHAN_DATA_W`=64 and `CHAN_MAX_BURST`=16.
- One sub-module `chan_skid_buf`: the 2-entry registered buffer, parameterised by width, with `in_ready = ~full`.

## Test plan
- Single requester 2 sends 5 beats with `out_ready`=1 → beats appear in order, 1 cycle after acceptance; grant releases when valid drops; `rr_ptr`=3.
- All 4 requesters continuously valid, MAX_BURST=16 → grant order 0,1,2,3,0; exactly 16 contiguous beats per grant; one idle bubble between grants.
- `out_ready` held low for 10 cycles mid-burst → `in_ready` drops after 2 accepted beats; no loss or duplication after release; total beat count matches.
- Requester 3 is granted with only requester 0 also valid → after the burst ends, next grant is 0 (wrap from 3 to 0).
- `reset` asserted mid-burst with 2 beats in skid → `out_valid`=0 and `in_ready`=0 asynchronously; after release, arbitration restarts at requester 0.
- With `CHAN_ARB_TAG_EN`, interleaved grants from 1 and 3 → `out_chan` matches the source of each beat.
